// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage. Forwards ALU results to
// writeback or performs word loads/stores over a req/gnt/rvalid port.
// Ports:
//   clk, rst                  clock, async active-high reset
//   ex_valid/addr/wdata/rd    instruction from execute
//   ex_regwe/memrd/memwr      register write, load, store controls
//   stall                     hold execute outputs while busy
//   dm_req/we/addr/wdata      data-memory request (zeroed when idle)
//   dm_gnt/rvalid/rdata       data-memory grant and read response
//   wb_valid/data/rd/regwe    registered writeback pulse and payload
//   mem_fault                 00 none, 01 misaligned, 10 timeout
module mem_stage #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [4:0]  ex_rd,
   input  logic        ex_regwe,
   input  logic        ex_memrd,
   input  logic        ex_memwr,
   output logic        stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_gnt,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_regwe,
   output logic [1:0]  mem_fault
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [7:0] LP_TMO = 8'(TIMEOUT);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic [31:2] r_addr;
   logic [31:0] r_wdata;
   logic [4:0]  r_rd;
   logic        r_regwe;
   logic        r_we;

   logic        r_wb_valid;
   logic [31:0] r_wb_data;
   logic [4:0]  r_wb_rd;
   logic        r_wb_regwe;
   logic [1:0]  r_fault;

   logic        w_memop;
   logic        w_misal;
   logic        w_start;
   logic        w_tmo;
   logic        w_fire;
   logic [31:0] w_data;
   logic [4:0]  w_rd;
   logic        w_regwe;
   logic [1:0]  w_fault;

   assign w_memop = ex_memrd | ex_memwr;
   assign w_misal = |ex_addr[1:0];
   assign w_start = (r_state == S_IDLE) & ex_valid & w_memop & ~w_misal;
   // Current cycle is the TIMEOUT-th one spent in REQ+WAIT.
   assign w_tmo   = (r_cnt + 8'd1) == LP_TMO;

   assign stall    = (r_state != S_IDLE);
   assign dm_req   = (r_state == S_REQ);
   assign dm_we    = dm_req & r_we;
   assign dm_addr  = dm_req ? {r_addr, 2'b00} : 32'd0;
   assign dm_wdata = dm_req ? r_wdata : 32'd0;

   assign wb_valid  = r_wb_valid;
   assign wb_data   = r_wb_data;
   assign wb_rd     = r_wb_rd;
   assign wb_regwe  = r_wb_regwe;
   assign mem_fault = r_fault;

   always_comb begin
      w_state_nxt = r_state;
      w_fire      = 1'b0;
      w_data      = r_wb_data;
      w_rd        = r_wb_rd;
      w_regwe     = r_wb_regwe;
      w_fault     = r_fault;
      unique case (r_state)
         S_IDLE: begin
            if (ex_valid) begin
               if (!w_memop) begin
                  w_fire  = 1'b1;
                  w_data  = ex_addr;
                  w_rd    = ex_rd;
                  w_regwe = ex_regwe;
                  w_fault = 2'b00;
               end else if (w_misal) begin
                  w_fire  = 1'b1;
                  w_data  = ex_addr;
                  w_rd    = ex_rd;
                  w_regwe = 1'b0;
                  w_fault = 2'b01;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
         end
         S_REQ: begin
            // Grant beats a timeout landing in the same cycle.
            if (dm_gnt) begin
               if (r_we) begin
                  w_state_nxt = S_IDLE;
                  w_fire      = 1'b1;
                  w_rd        = r_rd;
                  w_regwe     = 1'b0;
                  w_fault     = 2'b00;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else if (w_tmo) begin
               w_state_nxt = S_IDLE;
               w_fire      = 1'b1;
               w_rd        = r_rd;
               w_regwe     = 1'b0;
               w_fault     = 2'b10;
            end
         end
         S_WAIT: begin
            if (dm_rvalid) begin
               w_state_nxt = S_IDLE;
               w_fire      = 1'b1;
               w_data      = dm_rdata;
               w_rd        = r_rd;
               w_regwe     = r_regwe;
               w_fault     = 2'b00;
            end else if (w_tmo) begin
               w_state_nxt = S_IDLE;
               w_fire      = 1'b1;
               w_rd        = r_rd;
               w_regwe     = 1'b0;
               w_fault     = 2'b10;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_rd    <= 5'd0;
         r_regwe <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (r_state == S_IDLE) ? 8'd0 : r_cnt + 8'd1;
         if (w_start) begin
            r_addr  <= ex_addr[31:2];
            r_wdata <= ex_wdata;
            r_rd    <= ex_rd;
            r_regwe <= ex_regwe;
            r_we    <= ex_memwr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_data  <= 32'd0;
         r_wb_rd    <= 5'd0;
         r_wb_regwe <= 1'b0;
         r_fault    <= 2'b00;
      end else begin
         r_wb_valid <= w_fire;
         r_wb_data  <= w_data;
         r_wb_rd    <= w_rd;
         r_wb_regwe <= w_regwe;
         r_fault    <= w_fault;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (TIMEOUT=4).
// Table-driven single-cycle ops plus store/load/timeout/reset sequences.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic [4:0]  ex_rd;
   logic        ex_regwe;
   logic        ex_memrd;
   logic        ex_memwr;
   logic        stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_regwe;
   logic [1:0]  mem_fault;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .ex_valid  (ex_valid),
      .ex_addr   (ex_addr),
      .ex_wdata  (ex_wdata),
      .ex_rd     (ex_rd),
      .ex_regwe  (ex_regwe),
      .ex_memrd  (ex_memrd),
      .ex_memwr  (ex_memwr),
      .stall     (stall),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .wb_valid  (wb_valid),
      .wb_data   (wb_data),
      .wb_rd     (wb_rd),
      .wb_regwe  (wb_regwe),
      .mem_fault (mem_fault)
   );

   typedef struct {
      logic        chk_data;
      logic [31:0] data;
      logic        chk_rd;
      logic [4:0]  rd;
      logic        regwe;
      logic [1:0]  fault;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [4:0]  rd;
      logic        regwe;
      logic        memrd;
      logic        memwr;
      logic [31:0] exp_data;
      logic        exp_regwe;
      logic [1:0]  exp_fault;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mon();
      exp_t e;
      if (wb_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wb_unexpected: got wb_valid=1 expected 0");
         end else begin
            e = sb.pop_front();
            if (e.chk_data) chk("wb_data", wb_data, e.data);
            if (e.chk_rd) chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_regwe", {31'd0, wb_regwe}, {31'd0, e.regwe});
            chk("mem_fault", {30'd0, mem_fault}, {30'd0, e.fault});
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      mon();
   endtask

   task automatic push(input logic cd, input logic [31:0] d,
                       input logic cr, input logic [4:0] r,
                       input logic we, input logic [1:0] f);
      exp_t e;
      e.chk_data = cd;
      e.data     = d;
      e.chk_rd   = cr;
      e.rd       = r;
      e.regwe    = we;
      e.fault    = f;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] r, input logic we,
                        input logic rd_op, input logic wr_op);
      ex_valid = 1'b1;
      ex_addr  = a;
      ex_wdata = wd;
      ex_rd    = r;
      ex_regwe = we;
      ex_memrd = rd_op;
      ex_memwr = wr_op;
   endtask

   initial begin : main
      int n;
      tbl[0] = '{32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0,
                 32'h0000_1234, 1'b1, 2'b00};
      tbl[1] = '{32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0,
                 32'h0000_1234, 1'b1, 2'b00};
      tbl[2] = '{32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0,
                 32'h0000_1234, 1'b1, 2'b00};
      tbl[3] = '{32'h0000_0203, 5'd8,  1'b1, 1'b1, 1'b0,
                 32'h0000_0000, 1'b0, 2'b01};
      tbl[4] = '{32'hFFFF_FFFC, 5'd31, 1'b1, 1'b0, 1'b0,
                 32'hFFFF_FFFC, 1'b1, 2'b00};
      tbl[5] = '{32'h0000_0102, 5'd4,  1'b0, 1'b0, 1'b1,
                 32'h0000_0000, 1'b0, 2'b01};
      tbl[6] = '{32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0,
                 32'h0000_0000, 1'b0, 2'b00};
      tbl[7] = '{32'hA5A5_0000, 5'd17, 1'b1, 1'b0, 1'b0,
                 32'hA5A5_0000, 1'b1, 2'b00};

      rst       = 1'b1;
      ex_valid  = 1'b0;
      ex_addr   = 32'd0;
      ex_wdata  = 32'd0;
      ex_rd     = 5'd0;
      ex_regwe  = 1'b0;
      ex_memrd  = 1'b0;
      ex_memwr  = 1'b0;
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      dm_rdata  = 32'd0;
      #12;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
      chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
      chk("rst_dm_addr", dm_addr, 32'd0);
      chk("rst_dm_wdata", dm_wdata, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("rst_wb_regwe", {31'd0, wb_regwe}, 32'd0);
      chk("rst_fault", {30'd0, mem_fault}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Back-to-back single-cycle ops
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].addr, 32'h5555_0000, tbl[i].rd, tbl[i].regwe,
               tbl[i].memrd, tbl[i].memwr);
         push(tbl[i].exp_fault == 2'b00, tbl[i].exp_data, 1'b1,
              tbl[i].rd, tbl[i].exp_regwe, tbl[i].exp_fault);
         cyc();
         chk("tbl_stall", {31'd0, stall}, 32'd0);
         chk("tbl_dm_req", {31'd0, dm_req}, 32'd0);
      end
      ex_valid = 1'b0;
      cyc();
      chk("wb_single_pulse", {31'd0, wb_valid}, 32'd0);
      chk("wb_hold_data", wb_data, 32'hA5A5_0000);
      chk("tbl_drain", sb.size(), 32'd0);

      // Store, grant delayed two cycles
      drive(32'h0000_0100, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0, 1'b1);
      push(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 2'b00);
      cyc();
      ex_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("st_stall", {31'd0, stall}, 32'd1);
         chk("st_dm_req", {31'd0, dm_req}, 32'd1);
         chk("st_dm_we", {31'd0, dm_we}, 32'd1);
         chk("st_dm_addr", dm_addr, 32'h0000_0100);
         chk("st_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
         if (k == 2) dm_gnt = 1'b1;
         cyc();
      end
      dm_gnt = 1'b0;
      chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("st_idle_stall", {31'd0, stall}, 32'd0);
      chk("st_idle_req", {31'd0, dm_req}, 32'd0);
      chk("st_idle_addr", dm_addr, 32'd0);
      chk("st_idle_wdata", dm_wdata, 32'd0);

      // Load, granted at once, response three cycles after grant
      drive(32'h0000_0200, 32'h0000_0000, 5'd7, 1'b1, 1'b1, 1'b0);
      push(1'b1, 32'hCAFE_F00D, 1'b1, 5'd7, 1'b1, 2'b00);
      cyc();
      ex_valid = 1'b0;
      chk("ld_dm_req", {31'd0, dm_req}, 32'd1);
      chk("ld_dm_we", {31'd0, dm_we}, 32'd0);
      chk("ld_dm_addr", dm_addr, 32'h0000_0200);
      dm_gnt = 1'b1;
      cyc();
      dm_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("ld_wait_req", {31'd0, dm_req}, 32'd0);
         chk("ld_wait_stall", {31'd0, stall}, 32'd1);
         chk("ld_wait_addr", dm_addr, 32'd0);
         if (k == 2) begin
            dm_rvalid = 1'b1;
            dm_rdata  = 32'hCAFE_F00D;
         end
         cyc();
      end
      dm_rvalid = 1'b0;
      chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("ld_idle_stall", {31'd0, stall}, 32'd0);

      // Timeout: load granted, no response
      drive(32'h0000_0300, 32'h0000_0000, 5'd9, 1'b1, 1'b1, 1'b0);
      push(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 2'b10);
      cyc();
      ex_valid = 1'b0;
      dm_gnt   = 1'b1;
      n = 0;
      for (int k = 0; k < 20 && stall; k++) begin
         n++;
         cyc();
         dm_gnt = 1'b0;
      end
      dm_gnt = 1'b0;
      chk("tmo_cycles", n, 32'd4);
      chk("tmo_pulse", {31'd0, wb_valid}, 32'd1);
      dm_rvalid = 1'b1;
      dm_rdata  = 32'h1111_2222;
      cyc();
      chk("tmo_stray0", {31'd0, wb_valid}, 32'd0);
      cyc();
      chk("tmo_stray1", {31'd0, wb_valid}, 32'd0);
      dm_rvalid = 1'b0;
      chk("tmo_drain", sb.size(), 32'd0);

      // Reset while waiting for read data
      drive(32'h0000_0400, 32'h0000_0000, 5'd11, 1'b1, 1'b1, 1'b0);
      push(1'b1, 32'd0, 1'b1, 5'd11, 1'b1, 2'b00);
      cyc();
      ex_valid = 1'b0;
      dm_gnt   = 1'b1;
      cyc();
      dm_gnt = 1'b0;
      chk("rw_in_wait", {31'd0, stall}, 32'd1);
      #1;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("rw_dm_req", {31'd0, dm_req}, 32'd0);
      chk("rw_stall", {31'd0, stall}, 32'd0);
      chk("rw_wb_valid", {31'd0, wb_valid}, 32'd0);
      #1;
      rst = 1'b0;
      dm_rvalid = 1'b1;
      dm_rdata  = 32'h3333_4444;
      cyc();
      chk("rw_late0", {31'd0, wb_valid}, 32'd0);
      cyc();
      chk("rw_late1", {31'd0, wb_valid}, 32'd0);
      dm_rvalid = 1'b0;
      drive(32'h0000_0042, 32'h0000_0000, 5'd2, 1'b1, 1'b0, 1'b0);
      push(1'b1, 32'h0000_0042, 1'b1, 5'd2, 1'b1, 2'b00);
      cyc();
      ex_valid = 1'b0;
      chk("rw_alu_valid", {31'd0, wb_valid}, 32'd1);
      cyc();
      chk("final_drain", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the CPU pipeline, sitting directly after the execute stage and consuming its result (`exeOut`) and store operand (`RegData1_o`). It either forwards the ALU result to writeback or performs a word load/store to data memory through a request/grant/response handshake. While a memory transaction is outstanding it stalls upstream. It flags misaligned accesses and memory timeouts instead of hanging the pipeline.

## Interface
- `TIMEOUT`, 255: cycles spent in REQ+WAIT before the access is aborted (1..255).
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  execute stage presents an instruction.
- `ex_addr`  in  32  execute result (`exeOut`): ALU value or memory address.
- `ex_wdata`  in  32  store data (`RegData1_o`).
- `ex_rd`  in  5  destination register.
- `ex_regwe`  in  1  instruction writes a register.
- `ex_memrd`, `ex_memwr`  in  1 each  load / store; never both high.
- `stall`  out  1  upstream must hold `ex_*` stable.
- `dm_req`  out  1  memory request.
- `dm_we`  out  1  request is a write.
- `dm_addr`  out  32  word address (bits [1:0] always 0).
- `dm_wdata`  out  32  write data.
- `dm_gnt`  in  1  memory accepted the request this cycle.
- `dm_rvalid`  in  1  read data valid.
- `dm_rdata`  in  32  read data.
- `wb_valid`  out  1  one-cycle pulse: result for writeback.
- `wb_data`  out  32  load data or forwarded ALU value.
- `wb_rd`  out  5  destination register.
- `wb_regwe`  out  1  writeback enable (qualified by `wb_valid`).
- `mem_fault`  out  2  fault cause, valid with `wb_valid`: 00 none, 01 misaligned, 10 timeout.

## Operation
- FSM states: IDLE, REQ, WAIT.
- `stall` = (state != IDLE), combinational from state. The stage accepts `ex_*` only in IDLE with `ex_valid`=1.
- IDLE, accept, no memory op: register `wb_data`=`ex_addr`, `wb_rd`, `wb_regwe`=`ex_regwe`, `mem_fault`=00, `wb_valid`=1. Remain in IDLE.
- IDLE, accept, memory op with `ex_addr[1:0]`!=0: issue no request. `wb_valid`=1, `wb_regwe`=0, `mem_fault`=01. Remain in IDLE.
- IDLE, accept, aligned memory op: latch addr/wdata/rd/regwe/direction, clear timeout counter, go to REQ.
- REQ: `dm_req`=1, and `dm_addr`/`dm_we`/`dm_wdata` come from the latches and stay stable until grant.
  - `dm_gnt` on a store: `wb_valid`=1, `wb_regwe`=0, go to IDLE.
  - `dm_gnt` on a load: go to WAIT.
- WAIT: `dm_req`=0. On `dm_rvalid`: `wb_data`=`dm_rdata`, `wb_rd` latched, `wb_regwe`=latched regwe, `wb_valid`=1, go to IDLE.
- Timeout: an 8-bit counter increments each cycle in REQ or WAIT. If it equals `TIMEOUT` and the completing event (`dm_gnt` in REQ, `dm_rvalid` in WAIT) is absent, then `wb_valid`=1, `wb_regwe`=0, `mem_fault`=10, and the FSM goes to IDLE. A completion in the same cycle as the timeout wins.
- `dm_rvalid` in IDLE or REQ is ignored, including a late response after a timeout or reset.
- `dm_gnt` outside REQ is ignored.
- `dm_wdata`, `dm_we` and `dm_addr` are 0 whenever `dm_req`=0.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `stall`=0, `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_wdata`=0, `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `wb_regwe`=0, `mem_fault`=00, counter=0.
- Reset mid-transaction drops `dm_req` at once and discards the access with no `wb_valid`.
- ALU pass-through and misaligned accesses: `wb_valid` one cycle after accept, with back-to-back throughput of 1 per cycle.
- Store: `dm_req` rises the cycle after accept. `wb_valid` follows one cycle after `dm_gnt`, so minimum latency is 2.
- Load: minimum latency is 3 (accept, then req+gnt, then rvalid, then `wb_valid`).
- `wb_valid` is a registered single-cycle pulse. All `wb_*` outputs hold their last value when `wb_valid`=0.

## Test plan
- ALU forward: `ex_valid`=1, `ex_addr`=0x1234, `ex_rd`=5, `ex_regwe`=1 for 3 consecutive cycles -> three `wb_valid` pulses with `wb_data`=0x1234 and `wb_rd`=5; `stall` stays 0.
- Store, grant delayed 2 cycles: addr 0x100, wdata 0xDEADBEEF -> `dm_req`=1, `dm_we`=1, `dm_addr`=0x100 held 3 cycles; `stall`=1 throughout; `wb_valid`=1 with `wb_regwe`=0 the cycle after grant.
- Load: addr 0x200, grant immediately, `dm_rvalid` 3 cycles later with 0xCAFEF00D -> `wb_data`=0xCAFEF00D, `wb_rd`=latched rd, `wb_regwe`=1; `dm_req` low during WAIT.
- Misaligned: load at 0x203 -> no `dm_req`; `wb_valid`=1, `mem_fault`=01, `wb_regwe`=0 the next cycle.
- Timeout: `TIMEOUT`=4, load granted, `dm_rvalid` never asserted -> `mem_fault`=10 pulse and return to IDLE; a later stray `dm_rvalid` produces no `wb_valid`.
- Reset while in WAIT: `rst` pulsed -> `dm_req`/`stall`/`wb_valid` are 0 immediately; a subsequent `dm_rvalid` is ignored, and the next ALU op forwards normally.
